// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin arbiter sharing one ALU among several issue requesters
//
// Purpose
//   Grants the single ALU to one requester at a time in round-robin order.
//   It drives the ALU issue/accept handshake and steers each result back
//   to the requester that issued the op. Only one op is in flight.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   XLEN     result width, must match the ALU
//   IN_W     width of the packed ALU operand/control bundle
//
// Ports
//   clk_i              clock, all state on the rising edge
//   rst_ni             asynchronous active-low reset
//   req_i              per-requester op ready, held until granted
//   req_inputs_i       per-requester ALU bundle, slice i = [i*IN_W +: IN_W]
//   gnt_o              one-hot, op of requester i taken this cycle
//   rsp_valid_o        one-hot, result for requester i on rsp_data_o
//   rsp_data_o         ALU result (meaningful while any rsp_valid_o bit is set)
//   rsp_ack_i          requester i consumes its result this cycle
//   alu_ready_i        ALU can take a new op this cycle
//   alu_new_request_o  issue pulse to the ALU
//   alu_inputs_o       bundle of the granted requester, zero when no grant
//   alu_done_i         ALU result valid
//   alu_result_i       ALU result
//   alu_accepted_o     result consumed, ALU clears done
//   busy_o             an op is in flight
module alu_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int IN_W    = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*IN_W-1:0] req_inputs_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [XLEN-1:0]         rsp_data_o,
    input  logic [NUM_REQ-1:0]      rsp_ack_i,
    input  logic                    alu_ready_i,
    output logic                    alu_new_request_o,
    output logic [IN_W-1:0]         alu_inputs_o,
    input  logic                    alu_done_i,
    input  logic [XLEN-1:0]         alu_result_i,
    output logic                    alu_accepted_o,
    output logic                    busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] winner_next;
    logic [IDX_W-1:0] cand;
    logic             any_req;
    logic             op_release;
    logic             can_issue;
    logic             issue_out;

    // Round-robin search starting at rr_ptr_q. Walking the offsets from the
    // far end towards zero lets the closest requesting index overwrite
    // any earlier candidate, so the last assignment is the winner.
    always_comb begin
        winner = rr_ptr_q;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_i[cand]) begin
                winner = cand;
            end
        end
    end

    assign winner_next = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);

    assign any_req = |req_i;

    // The owner releasing its result frees the ALU in the same cycle, which
    // is what allows a new op to be issued back-to-back.
    assign op_release = (state_q == BUSY) && alu_done_i && rsp_ack_i[owner_q];

    assign can_issue = alu_ready_i && any_req && ((state_q == IDLE) || op_release);

    // Outputs are forced quiet while reset is held; the state registers are
    // already held by the asynchronous reset, so they use can_issue directly.
    assign issue_out = can_issue && rst_ni;

    always_comb begin
        gnt_o = '0;
        if (issue_out) begin
            gnt_o[winner] = 1'b1;
        end
    end

    assign alu_new_request_o = issue_out;
    assign alu_inputs_o      = issue_out ? req_inputs_i[int'(winner)*IN_W +: IN_W] : '0;

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == BUSY) begin
            rsp_valid_o[owner_q] = alu_done_i;
        end
    end

    assign rsp_data_o     = (state_q == BUSY) ? alu_result_i : '0;
    assign alu_accepted_o = op_release;
    assign busy_o         = (state_q == BUSY);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (can_issue) begin
            state_d  = BUSY;
            owner_d  = winner;
            rr_ptr_d = winner_next;
        end else if (op_release) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_rsp_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_valid_o));
    a_issue_matches_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
        alu_new_request_o == (|gnt_o));
    a_no_gnt_while_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((state_q == BUSY) && !op_release && (|gnt_o)));
    a_no_done_when_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((state_q == IDLE) && alu_done_i));
`endif

endmodule
